// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the iterative restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must be able to hold the value BITS itself.
  function automatic int unsigned cnt_width(input int unsigned bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract.
module div_step #(
  parameter int unsigned BITS = 8
) (
  input  logic [BITS:0]   rem_i,
  input  logic            quo_msb_i,
  input  logic [BITS-1:0] divisor_i,
  output logic [BITS:0]   rem_nxt_c,
  output logic            quo_bit_c
);

  logic [BITS:0] shifted;
  logic [BITS:0] trial;

  // The partial remainder is always below the divisor, so its top bit is zero and drops out.
  always_comb begin
    shifted   = (BITS+1)'({rem_i, quo_msb_i});
    trial     = shifted - {1'b0, divisor_i};
    quo_bit_c = ~trial[BITS];
    rem_nxt_c = quo_bit_c ? trial : shifted;
  end

endmodule

// File: rtl/div.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, valid/ready operand handshake.
module div
  import div_pkg::*;
#(
  parameter int unsigned BITS = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [BITS-1:0] i_op_a,
  input  logic [BITS-1:0] i_op_b,
  output logic            o_valid,
  output logic [BITS-1:0] o_quo,
  output logic [BITS-1:0] o_rem,
  output logic            o_div_by_zero
);

  localparam int unsigned CW = cnt_width(BITS);

  state_e          state_q, state_d;
  logic [BITS-1:0] quo_q, quo_d;
  logic [BITS-1:0] dvs_q, dvs_d;
  logic [BITS:0]   rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dbz_q, dbz_d;
  logic            valid_q, valid_d;
  logic            ready_q, ready_d;

  logic [BITS:0]   step_rem;
  logic            step_bit;

  div_step #(.BITS(BITS)) u_step (
    .rem_i     (rem_q),
    .quo_msb_i (quo_q[BITS-1]),
    .divisor_i (dvs_q),
    .rem_nxt_c (step_rem),
    .quo_bit_c (step_bit)
  );

  // Next-state and datapath update; valid/ready are registered from the next state.
  always_comb begin
    state_d = state_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    valid_d = 1'b0;
    ready_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          quo_d   = i_op_a;
          dvs_d   = i_op_b;
          rem_d   = '0;
          dbz_d   = (i_op_b == '0);
          cnt_d   = CW'(BITS);
          state_d = CALC;
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[BITS-2:0], step_bit};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    valid_d = (state_d == DONE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      quo_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign o_ready       = ready_q;
  assign o_valid       = valid_q;
  assign o_quo         = quo_q;
  assign o_rem         = rem_q[BITS-1:0];
  assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div (BITS=8): driver pushes golden results, negedge monitor checks them.
module tb_div;

  localparam int unsigned BITS = 8;
  // o_valid is seen at the negedge BITS rising edges after the accept edge.
  localparam int          LAT  = BITS;

  typedef struct {
    logic [BITS-1:0] quo;
    logic [BITS-1:0] rem;
    logic            dbz;
    int              acc;
  } exp_t;

  logic            clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_valid = 1'b0;
  logic [BITS-1:0] i_op_a = '0;
  logic [BITS-1:0] i_op_b = '0;
  logic            o_ready, o_valid, o_div_by_zero;
  logic [BITS-1:0] o_quo, o_rem;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   valid_cnt = 0;
  logic prev_valid = 1'b0;
  exp_t sb[$];

  div #(.BITS(BITS)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_op_a        (i_op_a),
    .i_op_b        (i_op_b),
    .o_valid       (o_valid),
    .o_quo         (o_quo),
    .o_rem         (o_rem),
    .o_div_by_zero (o_div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Golden model straight from the arithmetic definition.
  function automatic exp_t model(input logic [BITS-1:0] a, input logic [BITS-1:0] b, input int acc);
    exp_t e;
    if (b == '0) begin
      e.quo = '1;
      e.rem = a;
      e.dbz = 1'b1;
    end else begin
      e.quo = a / b;
      e.rem = a % b;
      e.dbz = 1'b0;
    end
    e.acc = acc;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic issue(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                       input bit hold, input bit push, output int acc);
    int n;
    i_op_a  = a;
    i_op_b  = b;
    i_valid = 1'b1;
    n = 0;
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("handshake_ready", o_ready, 1);
    acc = cyc + 1;
    if (push) sb.push_back(model(a, b, acc));
    @(negedge clk);
    if (!hold) i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !o_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  // Monitor: compares every o_valid pulse against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (prev_valid) begin
      chk("ready_after_valid", o_ready, 1);
      chk("valid_one_cycle", o_valid, 0);
    end
    prev_valid <= o_valid;
    if (o_valid) begin
      valid_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("quo", o_quo, e.quo);
        chk("rem", o_rem, e.rem);
        chk("div_by_zero", o_div_by_zero, e.dbz);
        chk("latency", cyc - e.acc, LAT);
      end
    end
  end

  initial begin
    int a1, a2, acc, vc;
    logic [BITS-1:0] ra, rb;

    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_quo", o_quo, 0);
    chk("rst_rem", o_rem, 0);
    chk("rst_dbz", o_div_by_zero, 0);

    issue(8'd100, 8'd7, 0, 1, acc);   drain();
    issue(8'd255, 8'd1, 0, 1, acc);   drain();
    issue(8'd3, 8'd10, 0, 1, acc);    drain();
    issue(8'd200, 8'd200, 0, 1, acc); drain();
    issue(8'd5, 8'd0, 0, 1, acc);     drain();

    // Back-to-back with operands changing while the first divide is in flight.
    issue(8'd90, 8'd9, 1, 1, a1);
    issue(8'd77, 8'd8, 0, 1, a2);
    chk("b2b_spacing", a2 - a1, BITS + 2);
    drain();

    // Reset four cycles into CALC discards the result.
    issue(8'd50, 8'd3, 0, 0, acc);
    repeat (3) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    chk("midrst_ready", o_ready, 1);
    chk("midrst_valid", o_valid, 0);
    chk("midrst_quo", o_quo, 0);
    chk("midrst_rem", o_rem, 0);
    chk("midrst_dbz", o_div_by_zero, 0);
    vc = valid_cnt;
    repeat (15) @(negedge clk);
    chk("midrst_no_valid", valid_cnt, vc);
    issue(8'd50, 8'd3, 0, 1, acc);    drain();

    // Random sweep, biased towards the 0 and all-ones corners, sometimes back-to-back.
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 9))
        0:       ra = '0;
        1:       ra = '1;
        default: ra = BITS'($urandom_range(0, 255));
      endcase
      case ($urandom_range(0, 9))
        0:       rb = '0;
        1:       rb = '1;
        2:       rb = 8'd1;
        default: rb = BITS'($urandom_range(0, 255));
      endcase
      issue(ra, rb, bit'($urandom_range(0, 1)), 1, acc);
    end
    i_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete by cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/div.md
Name: div

Overview:
- Iterative unsigned restoring divider: the inverse operation of the team's `mult` block.
- Registers a dividend/divisor pair on a valid/ready handshake.
- Produces one quotient bit per cycle, then presents quotient and remainder for one cycle.
- Sits alongside `mult` as an arithmetic benchmark/datapath block for synthesis characterisation.

Parameters:
- BITS, 8, operand/result width; legal range 2..64.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  operand pair valid.
- o_ready  out  1  block idle, can accept operands.
- i_op_a  in  BITS  dividend (unsigned).
- i_op_b  in  BITS  divisor (unsigned).
- o_valid  out  1  result valid, one-cycle pulse.
- o_quo  out  BITS  quotient.
- o_rem  out  BITS  remainder.
- o_div_by_zero  out  1  divisor was zero; qualified by o_valid.

Behaviour:
- Interface: one clock i_clk; reset i_rst is synchronous and active-high.
- Reset values: state=IDLE, o_ready=1, o_valid=0, o_quo=0, o_rem=0, o_div_by_zero=0, iteration counter=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid=1, capture dividend into quotient shift register and divisor into divisor register.
  - Clear partial remainder (BITS+1 bits).
  - Latch div_by_zero = (i_op_b==0).
  - Load counter=BITS and go to CALC.
- CALC:
  - o_ready=0.
  - Each cycle: trial = {rem[BITS-1:0], quo[BITS-1]} - {1'b0, divisor}.
  - If trial is non-negative (MSB=0): rem<=trial, shift quo left inserting 1.
  - Otherwise: rem<={rem[BITS-1:0], quo[BITS-1]}, shift quo left inserting 0.
  - Decrement counter; when it reaches 1 in this cycle, go to DONE.
- DONE:
  - o_valid=1 for exactly one cycle; o_ready=0.
  - Next state IDLE.
- Latency: accept edge at cycle T -> o_valid high during cycle T+BITS+1. Throughput is one division per BITS+2 cycles.
- o_quo/o_rem/o_div_by_zero hold their last result after o_valid falls, until the next result is written. During CALC they expose internal shift registers and are not meaningful.
- i_valid is ignored while o_ready=0. There is no queuing; the driver holds i_valid until the handshake.
- Divide by zero is handled by the same fixed latency with no special path. The algorithm naturally yields quo = all ones and rem = dividend; o_div_by_zero=1.
- Dividend < divisor: quo=0, rem=dividend.
- Reset mid-CALC or DONE: next cycle IDLE, o_valid=0, all outputs back to reset values, the in-flight result is discarded, and o_ready=1 immediately.
- Arithmetic widths:
  - Partial remainder is BITS+1 bits so the trial subtraction never overflows.
  - Final o_rem = rem[BITS-1:0].
  - Counter width = $clog2(BITS+1).
- No combinational path from any input to any output.

Decomposition:
- Package div_pkg:
  - state typedef (enum logic [1:0] {IDLE, CALC, DONE}).
  - localparam function for counter width.
- Optional sub-module div_step: purely combinational single restoring iteration.
  - Inputs: rem, quo MSB, divisor.
  - Outputs: next rem, quotient bit.
  - Lets a future unrolled/pipelined divider reuse the step.
- The top holds the FSM, counter and registers.

Test Plan (BITS=8):
- Reset, then 100 / 7 -> o_valid exactly 9 cycles after the accept cycle, o_quo=14, o_rem=2, o_div_by_zero=0; o_ready returns 1 the cycle after o_valid.
- 255 / 1 -> quo=255, rem=0. Then 3 / 10 -> quo=0, rem=3. Then 200 / 200 -> quo=1, rem=0.
- 5 / 0 -> quo=255, rem=5, o_div_by_zero=1, same 9-cycle latency.
- Back-to-back: i_valid held high with 90/9 then 77/8 -> results 10r0 and 9r5; accepts spaced exactly BITS+2=10 cycles; the operand change during CALC does not affect the first result.
- i_rst asserted 4 cycles into CALC for 50/3 -> no o_valid pulse. The next cycle has o_ready=1 and outputs 0. A following 50/3 gives 16r2.
- Randomised sweep, 1000 pairs including 0 and 255 operands -> every result matches the golden a/b and a%b (b=0 rule above) with constant latency.
